// File: rtl/rv32_alu_pkg.sv
// Shared definitions for the RV32 ALU and its two-requester arbiter:
// opcode encodings, source IDs and the output slot state type.
package rv32_alu_pkg;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam int         ALT_BIT = 3;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1101;

  localparam logic SRC_REQ0 = 1'b0;
  localparam logic SRC_REQ1 = 1'b1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/rv32_alu_arbiter_if.sv
// Request, response and debug signals of the shared-ALU arbiter.
// Handshake: a transfer happens on a rising edge where valid & ready are both 1;
// valid never depends on ready, and the payload is held while valid & !ready.
interface rv32_alu_arbiter_if
  import rv32_alu_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [31:0]      req0_op1;
  logic [31:0]      req0_op2;
  logic [3:0]       req0_opcode;
  logic [TAG_W-1:0] req0_tag;

  logic             req1_valid;
  logic             req1_ready;
  logic [31:0]      req1_op1;
  logic [31:0]      req1_op2;
  logic [3:0]       req1_opcode;
  logic [TAG_W-1:0] req1_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic             rsp_src;
  logic [TAG_W-1:0] rsp_tag;

  logic [CNT_W-1:0] acc_cnt0;
  logic [CNT_W-1:0] acc_cnt1;

  slot_state_e      dbg_state;
  logic             dbg_ptr;

  modport slave (
    input  req0_valid, req0_op1, req0_op2, req0_opcode, req0_tag,
    input  req1_valid, req1_op1, req1_op2, req1_opcode, req1_tag,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_result, rsp_src, rsp_tag,
    output acc_cnt0, acc_cnt1, dbg_state, dbg_ptr
  );

  modport master (
    output req0_valid, req0_op1, req0_op2, req0_opcode, req0_tag,
    output req1_valid, req1_op1, req1_op2, req1_opcode, req1_tag,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_result, rsp_src, rsp_tag,
    input  acc_cnt0, acc_cnt1, dbg_state, dbg_ptr
  );
endinterface

// File: rtl/rv32_alu.sv
// Combinational RV32I integer ALU; opcode[3] selects SUB for add and SRA for
// shift-right and is ignored for every other funct3.
module rv32_alu
  import rv32_alu_pkg::*;
(
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [3:0]  opcode,
  output logic [31:0] result
);
  logic [4:0] shamt;
  logic       alt;

  assign shamt = op2[4:0];
  assign alt   = opcode[ALT_BIT];

  always_comb begin
    result = '0;
    case (opcode[2:0])
      F3_ADD:  result = alt ? (op1 - op2) : (op1 + op2);
      F3_SLL:  result = op1 << shamt;
      F3_SLT:  result = {31'd0, $signed(op1) < $signed(op2)};
      F3_SLTU: result = {31'd0, op1 < op2};
      F3_XOR:  result = op1 ^ op2;
      F3_SRL:  result = alt ? $unsigned($signed(op1) >>> shamt) : (op1 >> shamt);
      F3_OR:   result = op1 | op2;
      F3_AND:  result = op1 & op2;
      default: result = '0;
    endcase
  end
endmodule

// File: rtl/rv32_alu_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; the pointer moves to the loser only when a
// grant is actually issued, so a stalled slot does not rotate priority.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic valid0,
  input  logic valid1,
  input  logic can_accept,
  output logic grant0,
  output logic grant1,
  output logic ptr
);
  assign grant0 = can_accept & valid0 & (~valid1 | ~ptr);
  assign grant1 = can_accept & valid1 & (~valid0 |  ptr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (grant0) begin
      ptr <= 1'b1;
    end else if (grant1) begin
      ptr <= 1'b0;
    end
  end
endmodule

// File: rtl/rv32_alu_arbiter.sv
// Shares one rv32_alu between two valid/ready requesters and registers each
// result, with its source and tag, into a single-entry response slot.
module rv32_alu_arbiter
  import rv32_alu_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
)(
  input logic clk,
  input logic rst,
  rv32_alu_arbiter_if.slave bus
);
  slot_state_e      state;
  logic             can_accept;
  logic             grant0;
  logic             grant1;
  logic             accept;
  logic [31:0]      alu_op1;
  logic [31:0]      alu_op2;
  logic [3:0]       alu_opcode;
  logic [31:0]      alu_result;
  logic [TAG_W-1:0] sel_tag;
  logic [31:0]      rsp_result_q;
  logic             rsp_src_q;
  logic [TAG_W-1:0] rsp_tag_q;
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  // A full slot can take a new result in the same cycle it is drained.
  assign can_accept = (state == SLOT_EMPTY) | bus.rsp_ready;

  rr_arb2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .valid0     (bus.req0_valid),
    .valid1     (bus.req1_valid),
    .can_accept (can_accept),
    .grant0     (grant0),
    .grant1     (grant1),
    .ptr        (bus.dbg_ptr)
  );

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign accept         = grant0 | grant1;

  assign alu_op1    = grant1 ? bus.req1_op1    : bus.req0_op1;
  assign alu_op2    = grant1 ? bus.req1_op2    : bus.req0_op2;
  assign alu_opcode = grant1 ? bus.req1_opcode : bus.req0_opcode;
  assign sel_tag    = grant1 ? bus.req1_tag    : bus.req0_tag;

  rv32_alu u_alu (
    .op1    (alu_op1),
    .op2    (alu_op2),
    .opcode (alu_opcode),
    .result (alu_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= SLOT_EMPTY;
      rsp_result_q <= '0;
      rsp_src_q    <= SRC_REQ0;
      rsp_tag_q    <= '0;
    end else begin
      case (state)
        SLOT_EMPTY: begin
          if (accept) begin
            state        <= SLOT_FULL;
            rsp_result_q <= alu_result;
            rsp_src_q    <= grant1 ? SRC_REQ1 : SRC_REQ0;
            rsp_tag_q    <= sel_tag;
          end
        end
        SLOT_FULL: begin
          if (accept) begin
            rsp_result_q <= alu_result;
            rsp_src_q    <= grant1 ? SRC_REQ1 : SRC_REQ0;
            rsp_tag_q    <= sel_tag;
          end else if (bus.rsp_ready) begin
            state <= SLOT_EMPTY;
          end
        end
        default: state <= SLOT_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (grant0 && (cnt0_q != {CNT_W{1'b1}})) cnt0_q <= cnt0_q + 1'b1;
      if (grant1 && (cnt1_q != {CNT_W{1'b1}})) cnt1_q <= cnt1_q + 1'b1;
    end
  end

  assign bus.rsp_valid  = (state == SLOT_FULL);
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_src    = rsp_src_q;
  assign bus.rsp_tag    = rsp_tag_q;
  assign bus.acc_cnt0   = cnt0_q;
  assign bus.acc_cnt1   = cnt1_q;
  assign bus.dbg_state  = state;
endmodule

// File: tb/tb_rv32_alu_arbiter.sv
// Bench for rv32_alu_arbiter: directed scenarios followed by random traffic,
// all checked against a cycle-level reference of the arbitration rules.
module tb_rv32_alu_arbiter;
  import rv32_alu_pkg::*;

  localparam int TAG_W   = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rv32_alu_arbiter_if #(.TAG_W(TAG_W), .CNT_W(CNT_W)) bus ();

  rv32_alu_arbiter #(.TAG_W(TAG_W), .CNT_W(CNT_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference state
  bit          m_full;
  logic [31:0] m_res;
  bit          m_src;
  logic [3:0]  m_tag;
  int          m_cnt0, m_cnt1;
  bit          m_ptr;
  bit          m_acc0, m_acc1;

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] opc);
    int unsigned sh;
    sh = b % 32;
    case (opc[2:0])
      3'd0: return opc[3] ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: begin
        if (opc[3] && a[31]) return ~((~a) >> sh);
        return a >> sh;
      end
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_full = 0; m_res = '0; m_src = 0; m_tag = '0;
    m_cnt0 = 0; m_cnt1 = 0; m_ptr = 0; m_acc0 = 0; m_acc1 = 0;
  endtask

  // Called #1 after a rising edge with inputs already driven; returns #1 after the next edge.
  task automatic cycle(input string tag);
    bit can, g0, g1;
    logic [31:0] nres;
    #1;
    can = !m_full || bus.rsp_ready;
    g0 = can && bus.req0_valid && (!bus.req1_valid || !m_ptr);
    g1 = can && bus.req1_valid && (!bus.req0_valid || m_ptr);
    chk({tag, "_req0_ready"}, 32'(bus.req0_ready), 32'(g0));
    chk({tag, "_req1_ready"}, 32'(bus.req1_ready), 32'(g1));
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(m_full));
    chk({tag, "_state"}, 32'(bus.dbg_state), 32'(m_full));
    chk({tag, "_ptr"}, 32'(bus.dbg_ptr), 32'(m_ptr));
    chk({tag, "_cnt0"}, 32'(bus.acc_cnt0), 32'(m_cnt0));
    chk({tag, "_cnt1"}, 32'(bus.acc_cnt1), 32'(m_cnt1));
    if (m_full) begin
      chk({tag, "_result"}, bus.rsp_result, m_res);
      chk({tag, "_src"}, 32'(bus.rsp_src), 32'(m_src));
      chk({tag, "_tag"}, 32'(bus.rsp_tag), 32'(m_tag));
    end
    nres = g1 ? ref_alu(bus.req1_op1, bus.req1_op2, bus.req1_opcode)
              : ref_alu(bus.req0_op1, bus.req0_op2, bus.req0_opcode);
    @(posedge clk);
    if (g0 || g1) begin
      m_full = 1;
      m_res  = nres;
      m_src  = g1;
      m_tag  = g1 ? bus.req1_tag : bus.req0_tag;
      m_ptr  = g0;
      if (g0 && m_cnt0 < CNT_MAX) m_cnt0++;
      if (g1 && m_cnt1 < CNT_MAX) m_cnt1++;
    end else if (bus.rsp_ready) begin
      m_full = 0;
    end
    m_acc0 = g0;
    m_acc1 = g1;
    #1;
  endtask

  task automatic drive0(input bit v, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] opc, input logic [3:0] tg);
    bus.req0_valid = v; bus.req0_op1 = a; bus.req0_op2 = b;
    bus.req0_opcode = opc; bus.req0_tag = tg;
  endtask

  task automatic drive1(input bit v, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] opc, input logic [3:0] tg);
    bus.req1_valid = v; bus.req1_op1 = a; bus.req1_op2 = b;
    bus.req1_opcode = opc; bus.req1_tag = tg;
  endtask

  initial begin
    logic [31:0] held;
    drive0(0, '0, '0, '0, '0);
    drive1(0, '0, '0, '0, '0);
    bus.rsp_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset values
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_result", bus.rsp_result, 32'd0);
    chk("rst_src", 32'(bus.rsp_src), 32'd0);
    chk("rst_tag", 32'(bus.rsp_tag), 32'd0);
    chk("rst_cnt0", 32'(bus.acc_cnt0), 32'd0);
    chk("rst_cnt1", 32'(bus.acc_cnt1), 32'd0);
    chk("rst_ptr", 32'(bus.dbg_ptr), 32'd0);

    // 1: single SUB from req0
    drive0(1, 32'd5, 32'd3, OP_SUB, 4'd7);
    bus.rsp_ready = 1'b1;
    cycle("t1");
    chk("t1_accepted", 32'(m_acc0), 32'd1);
    chk("t1_valid", 32'(bus.rsp_valid), 32'd1);
    chk("t1_result", bus.rsp_result, 32'd2);
    chk("t1_src", 32'(bus.rsp_src), 32'd0);
    chk("t1_tag", 32'(bus.rsp_tag), 32'd7);
    chk("t1_cnt0", 32'(bus.acc_cnt0), 32'd1);

    // 2: both valid, grants alternate; req1 performs SRA
    drive0(1, 32'd10, 32'd20, 4'b0000, 4'd1);
    drive1(1, 32'h8000_0000, 32'd4, OP_SRA, 4'd2);
    for (int i = 0; i < 4; i++) begin
      cycle("t2");
      chk("t2_alternate", 32'(m_acc1), 32'((i % 2) == 0));
      if (m_acc1) begin
        chk("t2_sra", bus.rsp_result, 32'hF800_0000);
        chk("t2_src", 32'(bus.rsp_src), 32'd1);
      end
    end

    // 3: backpressure with both requesters waiting
    bus.rsp_ready = 1'b0;
    held = bus.rsp_result;
    for (int i = 0; i < 3; i++) begin
      cycle("t3_stall");
      chk("t3_no_accept", 32'({m_acc0, m_acc1}), 32'd0);
      chk("t3_held", bus.rsp_result, held);
    end
    bus.rsp_ready = 1'b1;
    cycle("t3_release");
    chk("t3_release_acc", 32'(m_acc1), 32'd1);
    chk("t3_release_full", 32'(bus.rsp_valid), 32'd1);
    chk("t3_release_res", bus.rsp_result, 32'hF800_0000);

    // 4: signed vs unsigned compare
    drive1(0, '0, '0, '0, '0);
    drive0(1, 32'hFFFF_FFFF, 32'd1, 4'b0010, 4'd3);
    cycle("t4_slt");
    chk("t4_slt", bus.rsp_result, 32'd1);
    drive0(1, 32'hFFFF_FFFF, 32'd1, 4'b0011, 4'd4);
    cycle("t4_sltu");
    chk("t4_sltu", bus.rsp_result, 32'd0);

    // 5: asynchronous reset while full
    drive0(0, '0, '0, '0, '0);
    bus.rsp_ready = 1'b0;
    chk("t5_pre_full", 32'(bus.rsp_valid), 32'd1);
    chk("t5_pre_ptr", 32'(bus.dbg_ptr), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5_valid", 32'(bus.rsp_valid), 32'd0);
    chk("t5_ptr", 32'(bus.dbg_ptr), 32'd0);
    chk("t5_cnt0", 32'(bus.acc_cnt0), 32'd0);
    chk("t5_cnt1", 32'(bus.acc_cnt1), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    cycle("t5_after");

    // 6: counter saturation
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive0(1, 32'(i), 32'd1, 4'b0000, 4'(i));
      cycle("t6");
    end
    chk("t6_cnt0_sat", 32'(bus.acc_cnt0), 32'd3);
    chk("t6_cnt1", 32'(bus.acc_cnt1), 32'd0);
    drive0(0, '0, '0, '0, '0);

    // random traffic; a requester keeps its payload until accepted
    for (int n = 0; n < 400; n++) begin
      if (!bus.req0_valid || m_acc0)
        drive0($urandom_range(0, 1) == 1, $urandom, $urandom, 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)));
      if (!bus.req1_valid || m_acc1)
        drive1($urandom_range(0, 1) == 1, $urandom, $urandom, 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)));
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      cycle("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
